alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external registered ALU: queues commands, issues them with response-FIFO credit,
// and returns results in order. Define ALU_SEQ_STATUS_EN to add saturating issue / illegal-opcode counters.
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result,
    output logic        rsp_carry,
    output logic        rsp_err
`ifdef ALU_SEQ_STATUS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_err
`endif
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam logic [3:0] SEL_LAST_LEGAL = 4'b1000;

    // Illegal opcodes never expose whatever the ALU produced for them.
    function automatic logic [9:0] pack_rsp(input logic [7:0] result, input logic carry,
                                            input logic err);
        return err ? {8'h00, 1'b0, 1'b1} : {result, carry, 1'b0};
    endfunction

    logic [CPW:0]   cmd_wptr;
    logic [CPW:0]   cmd_rptr;
    logic [7:0]     cmd_a_mem   [CMD_DEPTH];
    logic [7:0]     cmd_b_mem   [CMD_DEPTH];
    logic [3:0]     cmd_sel_mem [CMD_DEPTH];
    logic           cmd_empty;
    logic           cmd_full;
    logic           cmd_push;
    logic [7:0]     head_a;
    logic [7:0]     head_b;
    logic [3:0]     head_sel;
    logic           head_illegal;

    logic [RPW:0]   rsp_wptr;
    logic [RPW:0]   rsp_rptr;
    logic [RPW:0]   rsp_count;
    logic [9:0]     rsp_mem [RSP_DEPTH];
    logic [9:0]     rsp_head;
    logic           rsp_empty;
    logic           rsp_push;
    logic           rsp_pop;

    logic           vld_p1;
    logic           err_p1;
    logic           vld_p2;
    logic           err_p2;
    logic [1:0]     inflight;
    logic [RPW+1:0] occupancy;
    logic           issue;

    assign cmd_empty    = (cmd_wptr == cmd_rptr);
    assign cmd_full     = (cmd_wptr[CPW] != cmd_rptr[CPW]) &&
                          (cmd_wptr[CPW-1:0] == cmd_rptr[CPW-1:0]);
    assign cmd_ready    = !reset && !cmd_full;
    assign cmd_push     = cmd_valid && cmd_ready;
    assign head_a       = cmd_a_mem[cmd_rptr[CPW-1:0]];
    assign head_b       = cmd_b_mem[cmd_rptr[CPW-1:0]];
    assign head_sel     = cmd_sel_mem[cmd_rptr[CPW-1:0]];
    assign head_illegal = (head_sel > SEL_LAST_LEGAL);

    // Credit counts queued responses plus those still in the ALU; a same-edge pop is not credited.
    assign rsp_count = rsp_wptr - rsp_rptr;
    assign inflight  = {1'b0, vld_p1} + {1'b0, vld_p2};
    assign occupancy = {1'b0, rsp_count} + {{RPW{1'b0}}, inflight};
    assign issue     = !cmd_empty && (occupancy < (RPW+2)'(RSP_DEPTH));

    // Stage p0: command FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wptr <= cmd_wptr + (CPW+1)'(1);
            end
            if (issue) begin
                cmd_rptr <= cmd_rptr + (CPW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_a_mem[cmd_wptr[CPW-1:0]]   <= cmd_a;
            cmd_b_mem[cmd_wptr[CPW-1:0]]   <= cmd_b;
            cmd_sel_mem[cmd_wptr[CPW-1:0]] <= cmd_sel;
        end
    end

    // Stage p1: operands registered toward the ALU, held between issues
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            alu_sel <= 4'b0000;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                alu_a   <= head_a;
                alu_b   <= head_b;
                alu_sel <= head_sel;
                err_p1  <= head_illegal;
            end
        end
    end

    // Stage p2: ALU has registered its result; capture on the following edge
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            err_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            err_p2 <= err_p1;
        end
    end

    assign rsp_push  = vld_p2;
    assign rsp_empty = (rsp_wptr == rsp_rptr);
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_mem[rsp_rptr[RPW-1:0]];

    // Response FIFO: credit check above guarantees a push never meets a full FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_wptr <= '0;
            rsp_rptr <= '0;
        end else begin
            if (rsp_push) begin
                rsp_wptr <= rsp_wptr + (RPW+1)'(1);
            end
            if (rsp_pop) begin
                rsp_rptr <= rsp_rptr + (RPW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem[rsp_wptr[RPW-1:0]] <= pack_rsp(alu_result, alu_carry, err_p2);
        end
    end

    // Storage is not cleared, so the outputs read zero whenever nothing is queued.
    assign {rsp_result, rsp_carry, rsp_err} = rsp_valid ? rsp_head : 10'h000;

`ifdef ALU_SEQ_STATUS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= 16'h0000;
            stat_err    <= 16'h0000;
        end else if (issue) begin
            stat_issued <= sat_inc16(stat_issued);
            if (head_illegal) begin
                stat_err <= sat_inc16(stat_err);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU stub plus an in-order response model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic [3:0] cmd_sel = 4'h0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_err;
`ifdef ALU_SEQ_STATUS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_err;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit stream_done = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    always #5 clk = ~clk;

    // ALU behaviour: returns {carry, result}
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
        logic [15:0] p;
        case (sel)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {(a < b), 8'(a - b)};
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return (b == 8'd0) ? 9'h100 : {1'b0, 8'(a / b)};
            4'd6: return {a[7], a[6:0], 1'b0};
            4'd7: return {a[0], 1'b0, a[7:1]};
            4'd8: begin
                p = 16'(a) * 16'(b);
                return {(p[15:8] != 8'h00), p[7:0]};
            end
            default: return 9'h1AA;
        endcase
    endfunction

    // Expected response word {result, carry, err}
    function automatic logic [9:0] model_rsp(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
        logic [8:0] r;
        if (sel > 4'd8) return {8'h00, 1'b0, 1'b1};
        r = alu_ref(a, b, sel);
        return {r[7:0], r[8], 1'b0};
    endfunction

    always_ff @(posedge clk) {alu_carry, alu_result} <= alu_ref(alu_a, alu_b, alu_sel);

    alu_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err)
`ifdef ALU_SEQ_STATUS_EN
        ,
        .stat_issued(stat_issued),
        .stat_err   (stat_err)
`endif
    );

    // Inputs only change just after posedge, so at negedge the handshakes for the next edge are settled.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (cmd_valid && cmd_ready) exp_q.push_back(model_rsp(cmd_a, cmd_b, cmd_sel));
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_result, rsp_carry, rsp_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                            input int budget, output bit ok);
        int k = 0;
        ok = 1'b0;
        cmd_a = a;
        cmd_b = b;
        cmd_sel = sel;
        cmd_valid = 1'b1;
        while (!ok && k < budget) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ok = 1'b1;
            tick();
            k++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_cmd_ready_low got=%b want=0", cmd_ready);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready_after got=%b want=1", cmd_ready);
        end
        checks++;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_err} !== 11'h000) begin
            failures++;
            $display("FAIL reset_rsp got=%b/%h/%b/%b want=0/00/0/0",
                     rsp_valid, rsp_result, rsp_carry, rsp_err);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 20'h00000) begin
            failures++;
            $display("FAIL reset_alu got=%h/%h/%h want=00/00/0", alu_a, alu_b, alu_sel);
        end
        tick();
    endtask

    task automatic test_add_latency();
        exp_q.delete();
        got_q.delete();
        rsp_ready = 1'b1;
        cmd_a = 8'd200;
        cmd_b = 8'd100;
        cmd_sel = 4'b0000;
        cmd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_accept got=%b want=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL add_early_rsp[E+%0d] got=%b want=0", k, rsp_valid);
            end
            if (k == 1) begin
                checks++;
                if ({alu_a, alu_b, alu_sel} !== {8'd200, 8'd100, 4'b0000}) begin
                    failures++;
                    $display("FAIL add_issue got=%0d/%0d/%h want=200/100/0", alu_a, alu_b, alu_sel);
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_err} !== {1'b1, 8'd44, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_rsp got=%b/%0d/%b/%b want=1/44/1/0",
                     rsp_valid, rsp_result, rsp_carry, rsp_err);
        end
        tick();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_single_rsp got=%b want=0", rsp_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== {8'd200, 8'd100, 4'b0000}) begin
            failures++;
            $display("FAIL alu_hold got=%0d/%0d/%h want=200/100/0", alu_a, alu_b, alu_sel);
        end
        tick();
    endtask

    task automatic test_illegal();
        bit ok;
        exp_q.delete();
        got_q.delete();
        rsp_ready = 1'b1;
        push_cmd(8'd5, 8'd3, 4'b1111, 10, ok);
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL illegal_timeout got=%0d want=1 responses", got_q.size());
        end else if (got_q[0] !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL illegal_rsp got=%h want=%h", got_q[0], {8'h00, 1'b0, 1'b1});
        end
`ifdef ALU_SEQ_STATUS_EN
        checks++;
        if ({stat_issued, stat_err} !== {16'd2, 16'd1}) begin
            failures++;
            $display("FAIL illegal_stat got=%0d/%0d want=2/1", stat_issued, stat_err);
        end
`endif
        tick();
    endtask

    task automatic test_div_zero();
        bit ok;
        exp_q.delete();
        got_q.delete();
        rsp_ready = 1'b1;
        push_cmd(8'd9, 8'd0, 4'b0101, 10, ok);
        push_cmd(8'd9, 8'd2, 4'b0101, 10, ok);
        wait_rsp(2, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL div_timeout got=%0d want=2 responses", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== {8'd0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL div_by_zero got=%h want=%h", got_q[0], {8'd0, 1'b1, 1'b0});
            end
            checks++;
            if (got_q[1] !== {8'd4, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL div_9_2 got=%h want=%h", got_q[1], {8'd4, 1'b0, 1'b0});
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] a9;
        logic [7:0] b9;
        logic [3:0] s9;
        exp_q.delete();
        got_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     4'($urandom_range(0, 15)), 1, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL bp_accept[%0d] got=not accepted want=accepted", i);
            end
        end
        a9 = 8'($urandom_range(0, 255));
        b9 = 8'($urandom_range(0, 255));
        s9 = 4'($urandom_range(0, 8));
        cmd_a = a9;
        cmd_b = b9;
        cmd_sel = s9;
        cmd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_full[%0d] cmd_ready got=%b want=0", k, cmd_ready);
            end
            if (k == 5) begin
                checks++;
                if (rsp_valid !== 1'b1 || {rsp_result, rsp_carry, rsp_err} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL bp_head got=%b/%h want=1/%h", rsp_valid,
                             {rsp_result, rsp_carry, rsp_err}, exp_q[0]);
                end
            end
            tick();
        end
        rsp_ready = 1'b1;
        push_cmd(a9, b9, s9, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_ninth got=not accepted want=accepted");
        end
        wait_rsp(9, 60, ok);
        tick();
        tick();
        checks++;
        if (got_q.size() !== 9 || exp_q.size() !== 9) begin
            failures++;
            $display("FAIL bp_count got=%0d want=9 (accepted %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        exp_q.delete();
        got_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     4'($urandom_range(0, 8)), 1, ok);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_rsp[%0d] got=%b want=0", k, rsp_valid);
            end
            tick();
        end
        checks++;
        if (got_q.size() !== 0) begin
            failures++;
            $display("FAIL midreset_popped got=%0d want=0", got_q.size());
        end
        push_cmd(8'd10, 8'd3, 4'b0001, 5, ok);
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_sub_timeout got=%0d want=1 responses", got_q.size());
        end else if (got_q[0] !== {8'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_sub got=%h want=%h", got_q[0], {8'd7, 1'b0, 1'b0});
        end
`ifdef ALU_SEQ_STATUS_EN
        checks++;
        if ({stat_issued, stat_err} !== {16'd1, 16'd0}) begin
            failures++;
            $display("FAIL midreset_stat got=%0d/%0d want=1/0", stat_issued, stat_err);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c0;
        exp_q.delete();
        got_q.delete();
        rsp_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     4'($urandom_range(0, 15)), 4, ok);
        end
        checks++;
        if (cyc - c0 !== 16) begin
            failures++;
            $display("FAIL b2b_accept_cycles got=%0d want=16", cyc - c0);
        end
        wait_rsp(16, 40, ok);
        checks++;
        if (cyc - c0 !== 20) begin
            failures++;
            $display("FAIL b2b_drain_cycles got=%0d want=20", cyc - c0);
        end
        checks++;
        if (got_q.size() !== 16 || exp_q.size() !== 16) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=16 (accepted %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        tick();
    endtask

    task automatic test_stream();
        bit ok;
        exp_q.delete();
        got_q.delete();
        stream_done = 1'b0;
        ok = 1'b0;
        fork
            begin
                while (!stream_done) begin
                    rsp_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
            begin
                for (int i = 0; i < 64; i++) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                    push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             4'($urandom_range(0, 8)), 200, ok);
                end
                wait_rsp(64, 2000, ok);
                stream_done = 1'b1;
            end
        join
        rsp_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (got_q.size() !== 64 || exp_q.size() !== 64) begin
            failures++;
            $display("FAIL stream_count got=%0d want=64 (accepted %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stream_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_illegal();
        test_div_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
